shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Command sequencer for the team's 4-bit universal shift register (hold / shift-left / shift-right / parallel-load via a 2-bit control). It accepts one command at a time over a valid/ready handshake and drives the register's control and data inputs for the required number of cycles. Supported commands are parallel load, clear, multi-bit shift with serial fill, and multi-bit rotate. It exposes the serial output stream and a done pulse with the final register value. It sits between a host/FSM and the shift register, and is the register's only driver.

## Interface
- WIDTH, 4: shift register width.
- CW, 3: width of cmd_count; the maximum count is 2^CW-1.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 SHIFT, 10 ROTATE, 11 CLEAR.
- cmd_dir  in  1  0 = left (toward MSB), 1 = right (toward LSB).
- cmd_count  in  CW  number of shift/rotate steps; ignored for LOAD/CLEAR.
- cmd_data  in  WIDTH  LOAD value.
- ser_in  in  1  fill bit for SHIFT, sampled combinationally in each shift cycle.
- q_in  in  WIDTH  current shift register output.
- sr_cntrl  out  2  to register: 00 hold, 01 shl (fill from d[0]), 10 shr (fill from d[WIDTH-1]), 11 load.
- sr_d  out  WIDTH  to register data input.
- ser_out  out  1  bit leaving the register this cycle.
- ser_out_valid  out  1  high during each SHIFT/ROTATE step.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  q_in captured in the DONE cycle; held until the next DONE.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - EXEC: drives the register.
  - DONE: done=1.
- Command capture:
  - Accept occurs on clk when cmd_valid && cmd_ready.
  - cmd_op, cmd_dir, cmd_count and cmd_data are latched at accept.
  - Later changes on the cmd_* inputs have no effect until the next accept.
- Transitions:
  - IDLE→EXEC on accept, except SHIFT/ROTATE with count 0, which goes IDLE→DONE.
  - EXEC→DONE when the step counter reaches the latched count (LOAD/CLEAR: after 1 cycle).
  - DONE→IDLE unconditionally.
- EXEC outputs per op:
  - LOAD: sr_cntrl=11, sr_d=latched data.
  - CLEAR: sr_cntrl=11, sr_d=0.
  - SHIFT: sr_cntrl=01 (left) or 10 (right); sr_d={WIDTH{ser_in}}.
  - ROTATE: as SHIFT, but fill = outgoing bit (left: q_in[WIDTH-1]; right: q_in[0]), replicated on sr_d.
- Serial output:
  - ser_out = q_in[WIDTH-1] (left) or q_in[0] (right), valid with ser_out_valid.
  - Outside shift steps, ser_out=0 and ser_out_valid=0.
- Outside EXEC: sr_cntrl=00, sr_d=0, so the register holds.
- Step counter:
  - CW bits, cleared at accept, incremented each EXEC cycle.
  - No wrap is possible, because exit occurs at count ≤ 2^CW-1.
- Reset values:
  - State IDLE; counter 0; latched command fields 0.
  - Outputs: result=0, done=0, busy=0, cmd_ready=1, sr_cntrl=00, sr_d=0, ser_out=0, ser_out_valid=0.
- Reset mid-command:
  - Aborts immediately and returns to IDLE.
  - No done pulse; result is cleared.
  - Register contents are whatever the completed steps produced (the register's own reset is separate).
- Commands while busy: cmd_ready=0, so there is no accept; the host must hold cmd_valid.

## Timing
- Accept at edge T:
  - EXEC occupies cycles T+1..T+N (N = count; 1 for LOAD/CLEAR).
  - DONE is in cycle T+N+1; result is registered at the end of that cycle.
  - cmd_ready rises in cycle T+N+2.
- Count-0 SHIFT/ROTATE: DONE in T+1, no register activity, result = unchanged q_in.
- Minimum accept-to-accept spacing is N+2 cycles.
- A command held on cmd_valid through DONE is accepted on the first IDLE edge.
- done is high exactly one cycle per completed command; busy is high from T+1 through T+N+1 inclusive.
- sr_cntrl and sr_d are combinational from state and latched fields (plus ser_in/q_in for fill); the register sees them at the same edge.

## Test plan
- LOAD 4'b1011 accepted at T → sr_cntrl=11 in T+1, done in T+2 with result=1011, cmd_ready=1 in T+3.
- After a LOAD of 1011: SHIFT right by 2 with ser_in=0 → ser_out sequence 1,1 with ser_out_valid, result=0010, done at T+3.
- After a LOAD of 1011: ROTATE left by 1 → 0111; then ROTATE right by 4 → unchanged 0111, done at T+5, ser_out sequence 1,1,1,0.
- After a CLEAR: SHIFT left by 3 with ser_in=1 → result=0111. Then SHIFT with count 0 → done at T+1, result unchanged, sr_cntrl stays 00.
- cmd_valid held high continuously with alternating ops → each accept occurs only in IDLE; no command is lost or double-executed; spacing is N+2.
- reset asserted in the 2nd step of a ROTATE-by-3 → all outputs at reset values immediately, no done pulse, cmd_ready=1 after release; the next LOAD executes normally.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register: accepts one LOAD/SHIFT/ROTATE/CLEAR
// command per handshake and drives the register's control/data inputs for the required cycles.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CW-1:0]    cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       sr_cntrl,
  output logic [WIDTH-1:0] sr_d,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SHIFT = 2'b01, OP_ROTATE = 2'b10, OP_CLEAR = 2'b11} op_t;

  state_t           state, state_next;
  op_t              op_q;
  logic             dir_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    step_cnt;
  logic             accept;
  logic             is_step_op;
  logic             last_step;
  logic             out_bit;
  logic             fill_bit;

  assign accept     = cmd_valid && (state == ST_IDLE);
  assign is_step_op = (op_q == OP_SHIFT) || (op_q == OP_ROTATE);
  // step_cnt holds the number of steps already completed, so the final step is count_q-1
  assign last_step  = (step_cnt == (count_q - CW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_LOAD;
      dir_q    <= 1'b0;
      count_q  <= '0;
      data_q   <= '0;
      step_cnt <= '0;
      result   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q     <= op_t'(cmd_op);
        dir_q    <= cmd_dir;
        count_q  <= cmd_count;
        data_q   <= cmd_data;
        step_cnt <= '0;
      end else if (state == ST_EXEC) begin
        step_cnt <= step_cnt + CW'(1);
      end
      if (state == ST_DONE) begin
        result <= q_in;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (((op_t'(cmd_op) == OP_SHIFT) || (op_t'(cmd_op) == OP_ROTATE)) && (cmd_count == '0)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (!is_step_op || last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_cntrl      = 2'b00;
    sr_d          = '0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    out_bit       = dir_q ? q_in[0] : q_in[WIDTH-1];
    fill_bit      = (op_q == OP_ROTATE) ? out_bit : ser_in;
    cmd_ready     = (state == ST_IDLE);
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    if (state == ST_EXEC) begin
      unique case (op_q)
        OP_LOAD: begin
          sr_cntrl = 2'b11;
          sr_d     = data_q;
        end
        OP_CLEAR: begin
          sr_cntrl = 2'b11;
          sr_d     = '0;
        end
        OP_SHIFT, OP_ROTATE: begin
          sr_cntrl      = dir_q ? 2'b10 : 2'b01;
          sr_d          = {WIDTH{fill_bit}};
          ser_out       = out_bit;
          ser_out_valid = 1'b1;
        end
        default: begin
          sr_cntrl = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl driving a behavioural 4-bit universal shift register.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sr_rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic       ser_in;
  logic [3:0] q;
  logic [1:0] sr_cntrl;
  logic [3:0] sr_d;
  logic       ser_out;
  logic       ser_out_valid;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(4), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_dir(cmd_dir),
    .cmd_count(cmd_count), .cmd_data(cmd_data), .ser_in(ser_in), .q_in(q),
    .sr_cntrl(sr_cntrl), .sr_d(sr_d), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .busy(busy), .done(done), .result(result)
  );

  // Universal shift register under control of the DUT, with its own reset
  always_ff @(posedge clk) begin
    if (sr_rst) q <= '0;
    else begin
      case (sr_cntrl)
        2'b01:   q <= {q[2:0], sr_d[0]};
        2'b10:   q <= {sr_d[3], q[3:1]};
        2'b11:   q <= sr_d;
        default: q <= q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in an IDLE cycle, let it be accepted, and return settled in cycle T+1
  task automatic issue(input logic [1:0] op, input logic dir, input logic [2:0] cnt, input logic [3:0] data);
    cmd_op = op; cmd_dir = dir; cmd_count = cnt; cmd_data = data; cmd_valid = 1'b1;
    #1;
    chk("issue_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_dir = 1'b0; cmd_count = '0; cmd_data = '0;
    #1;
  endtask

  logic [1:0] t_op   [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
  logic       t_dir  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0] t_cnt  [4] = '{3'd0, 3'd2, 3'd0, 3'd3};
  logic [3:0] t_data [4] = '{4'b0101, 4'b0000, 4'b0110, 4'b0000};
  logic [3:0] t_res  [4] = '{4'b0101, 4'b0100, 4'b0110, 4'b1100};
  int         t_gap  [3] = '{3, 4, 3};

  initial begin
    reset = 1'b1; sr_rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dir = 1'b0;
    cmd_count = '0; cmd_data = '0; ser_in = 1'b0;
    tick(); tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cntrl", sr_cntrl, 0);
    chk("rst_d", sr_d, 0);
    chk("rst_serv", {ser_out, ser_out_valid}, 0);
    reset = 1'b0; sr_rst = 1'b0;
    tick();

    // LOAD 1011
    issue(2'b00, 1'b0, 3'd0, 4'b1011);
    chk("load_cntrl", sr_cntrl, 2'b11);
    chk("load_d", sr_d, 4'b1011);
    chk("load_busy", {busy, cmd_ready, done}, 3'b100);
    tick();
    chk("load_done", {done, busy}, 2'b11);
    tick();
    chk("load_result", result, 4'b1011);
    chk("load_ready", {cmd_ready, done}, 2'b10);

    // SHIFT right by 2, fill 0
    ser_in = 1'b0;
    issue(2'b01, 1'b1, 3'd2, 4'b1111);
    chk("shr_cntrl", sr_cntrl, 2'b10);
    chk("shr_d", sr_d, 4'b0000);
    chk("shr_ser1", {ser_out_valid, ser_out}, 2'b11);
    tick();
    chk("shr_ser2", {ser_out_valid, ser_out}, 2'b11);
    chk("shr_nodone", done, 0);
    tick();
    chk("shr_done", {done, ser_out_valid}, 2'b10);
    tick();
    chk("shr_result", result, 4'b0010);

    // Restore 1011, ROTATE left by 1
    issue(2'b00, 1'b0, 3'd0, 4'b1011);
    tick(); tick();
    ser_in = 1'b0;
    issue(2'b10, 1'b0, 3'd1, 4'b0000);
    chk("rol_cntrl", sr_cntrl, 2'b01);
    chk("rol_d", sr_d, 4'b1111);
    chk("rol_ser", {ser_out_valid, ser_out}, 2'b11);
    tick();
    chk("rol_done", done, 1);
    tick();
    chk("rol_result", result, 4'b0111);

    // ROTATE right by 4 returns the same value; outgoing bits 1,1,1,0
    issue(2'b10, 1'b1, 3'd4, 4'b0000);
    chk("ror_ser1", {ser_out_valid, ser_out}, 2'b11);
    tick();
    chk("ror_ser2", {ser_out_valid, ser_out}, 2'b11);
    tick();
    chk("ror_ser3", {ser_out_valid, ser_out}, 2'b11);
    tick();
    chk("ror_ser4", {ser_out_valid, ser_out, sr_d}, 6'b10_0000);
    chk("ror_nodone", done, 0);
    tick();
    chk("ror_done", done, 1);
    tick();
    chk("ror_result", result, 4'b0111);

    // CLEAR then SHIFT left by 3 with fill 1
    issue(2'b11, 1'b0, 3'd5, 4'b1111);
    chk("clr_cntrl", {sr_cntrl, sr_d}, 6'b11_0000);
    tick(); tick();
    chk("clr_result", result, 4'b0000);
    ser_in = 1'b1;
    issue(2'b01, 1'b0, 3'd3, 4'b0000);
    chk("shl_d", {sr_cntrl, sr_d}, 6'b01_1111);
    tick(); tick(); tick();
    chk("shl_done", done, 1);
    tick();
    chk("shl_result", result, 4'b0111);

    // SHIFT with count 0: straight to DONE, register untouched
    issue(2'b01, 1'b1, 3'd0, 4'b0000);
    chk("cnt0_done", {done, busy}, 2'b11);
    chk("cnt0_cntrl", sr_cntrl, 2'b00);
    chk("cnt0_serv", ser_out_valid, 0);
    tick();
    chk("cnt0_result", result, 4'b0111);
    chk("cnt0_q", q, 4'b0111);
    ser_in = 1'b0;

    // cmd_valid held high across back-to-back commands
    begin
      int  acc_idx  = 0;
      int  done_cnt = 0;
      int  res_idx  = 0;
      int  last_acc = 0;
      bit  chk_res  = 1'b0;
      for (int c = 0; c < 60 && !(done_cnt == 4 && !chk_res); c++) begin
        if (acc_idx < 4) begin
          cmd_op = t_op[acc_idx]; cmd_dir = t_dir[acc_idx];
          cmd_count = t_cnt[acc_idx]; cmd_data = t_data[acc_idx]; cmd_valid = 1'b1;
        end else begin
          cmd_valid = 1'b0;
        end
        #1;
        if (chk_res) begin
          if (res_idx < 4) chk("b2b_result", result, t_res[res_idx]);
          res_idx++;
          chk_res = 1'b0;
        end
        if (done) begin
          done_cnt++;
          chk_res = 1'b1;
        end
        if (cmd_valid && cmd_ready) begin
          if (acc_idx > 0) chk("b2b_gap", c - last_acc, t_gap[acc_idx-1]);
          last_acc = c;
          acc_idx++;
        end else if (cmd_valid) begin
          chk("b2b_hold_busy", busy, 1);
        end
        tick();
      end
      cmd_valid = 1'b0;
      chk("b2b_accepts", acc_idx, 4);
      chk("b2b_dones", done_cnt, 4);
    end

    // Reset during the 2nd step of a ROTATE-by-3
    issue(2'b00, 1'b0, 3'd0, 4'b1011);
    tick(); tick();
    chk("pre_rst_result", result, 4'b1011);
    issue(2'b10, 1'b0, 3'd3, 4'b0000);
    tick();
    chk("mid_step2", {ser_out_valid, q}, 5'b1_0111);
    reset = 1'b1;
    #1;
    chk("abort_ready", {cmd_ready, busy, done}, 3'b100);
    chk("abort_out", {sr_cntrl, sr_d, ser_out, ser_out_valid}, 8'h00);
    chk("abort_result", result, 0);
    tick();
    chk("abort_nodone", done, 0);
    chk("abort_q", q, 4'b0111);
    #2 reset = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    tick();
    issue(2'b00, 1'b0, 3'd0, 4'b1001);
    chk("post_load_cntrl", sr_cntrl, 2'b11);
    tick();
    chk("post_load_done", done, 1);
    tick();
    chk("post_load_result", result, 4'b1001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
